// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between port 0 (CPU) and port 1 (debug/DMA).
// Optional macro DMEM_ARB_WRPROT_EN blocks port-1 writes at or above PROT_BASE and flags them on p1_err.
module dmem_arbiter #(
  parameter int                 ADDR_W    = 8,
  parameter int                 DATA_W    = 8,
  parameter logic [ADDR_W-1:0]  PROT_BASE = 8'hF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
  logic                winner;
  logic                wr_block;

`ifdef DMEM_ARB_WRPROT_EN
  assign wr_block = gnt_q & we_q & (addr_q >= PROT_BASE);
`else
  assign wr_block = 1'b0;
`endif

  // With both ports requesting the rr pointer decides; otherwise whoever asks wins.
  assign winner = (p0_req & p1_req) ? rr_q : p1_req;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (p0_req | p1_req) begin
          gnt_d   = winner;
          we_d    = winner ? p1_we    : p0_we;
          addr_d  = winner ? p1_addr  : p0_addr;
          wdata_d = winner ? p1_wdata : p0_wdata;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          if (gnt_q) p1_rdata_d = mem_read_data;
          else       p0_rdata_d = mem_read_data;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        rr_d    = ~gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // Memory strobes are gated by rst directly so a reset edge never commits a write.
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    if (state_q == S_ACCESS) begin
      mem_address    = addr_q;
      mem_write_data = wdata_q;
      mem_write      = we_q & ~rst & ~wr_block;
      mem_read       = ~we_q & ~rst;
    end
  end

  assign p0_done  = (state_q == S_RESP) & ~gnt_q;
  assign p1_done  = (state_q == S_RESP) & gnt_q;
  assign p1_err   = (state_q == S_RESP) & wr_block;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected done/rdata/err queued at stimulus, popped at each done pulse.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p0_req = 1'b0, p0_we = 1'b0;
  logic [7:0] p0_addr = '0, p0_wdata = '0;
  logic       p1_req = 1'b0, p1_we = 1'b0;
  logic [7:0] p1_addr = '0, p1_wdata = '0;
  logic       p0_done, p1_done, p1_err, busy;
  logic [7:0] p0_rdata, p1_rdata;
  logic [7:0] mem_address, mem_write_data, mem_read_data;
  logic       mem_write, mem_read;

  logic [7:0] mem [256];
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = '0, bd_data = '0;

  typedef struct packed {
    logic       port;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

`ifdef DMEM_ARB_WRPROT_EN
  localparam logic PROT_ON = 1'b1;
`else
  localparam logic PROT_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end
  assign mem_read_data = mem[mem_address];

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .PROT_BASE(8'hF0)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk); bd_we = 1'b0;
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [7:0] a, input logic [7:0] d);
    if (port) begin p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; end
    else      begin p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; end
  endtask

  // Waits (bounded) for a done pulse, then pops and checks it; returns elapsed negedges.
  task automatic wait_done(input int budget, output int cyc);
    exp_t       e;
    bit         seen;
    logic [7:0] got;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (p0_done || p1_done) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end else if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_done: p0_done=%b p1_done=%b with empty scoreboard", p0_done, p1_done);
    end else begin
      e = sb.pop_front();
      if ({p1_done, p0_done} !== (e.port ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL done_port: got {p1,p0}_done=%b%b expected port %0d", p1_done, p0_done, e.port);
      end
      got = e.port ? p1_rdata : p0_rdata;
      tests++;
      if (got !== e.rdata) begin
        fails++;
        $display("FAIL rdata_p%0d: got %h expected %h", e.port, got, e.rdata);
      end
      tests++;
      if (p1_err !== e.err) begin
        fails++;
        $display("FAIL p1_err: got %b expected %b", p1_err, e.err);
      end
    end
  endtask

  task automatic access(input logic port, input logic we, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd, input logic exp_err);
    int cyc;
    @(negedge clk);
    drive(port, 1'b1, we, a, d);
    sb.push_back('{port: port, rdata: exp_rd, err: exp_err});
    wait_done(10, cyc);
    drive(port, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({busy, p0_done, p1_done, p1_err, mem_write, mem_read} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got busy,d0,d1,err,mw,mr=%b%b%b%b%b%b expected 000000",
               busy, p0_done, p1_done, p1_err, mem_write, mem_read);
    end
    tests++;
    if (p0_rdata !== 8'h00 || p1_rdata !== 8'h00) begin
      fails++;
      $display("FAIL reset_rdata: got p0=%h p1=%h expected 00 00", p0_rdata, p1_rdata);
    end
    tests++;
    if (mem_address !== 8'h00) begin
      fails++;
      $display("FAIL idle_addr: got %h expected 00", mem_address);
    end
  endtask

  task automatic test_single_read();
    int cyc;
    poke(8'h0A, 8'd20);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h0A, 8'h00);
    sb.push_back('{port: 1'b0, rdata: 8'd20, err: 1'b0});
    @(negedge clk);
    tests++;
    if ({busy, mem_read, mem_write, p0_done} !== 4'b1100 || mem_address !== 8'h0A) begin
      fails++;
      $display("FAIL access_cycle: got busy,mr,mw,d0=%b%b%b%b addr=%h expected 1100 0a",
               busy, mem_read, mem_write, p0_done, mem_address);
    end
    wait_done(10, cyc);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tests++;
    if (cyc != 1) begin
      fails++;
      $display("FAIL read_latency: done %0d cycles after ACCESS, expected 1", cyc);
    end
  endtask

  task automatic test_write_read();
    access(1'b1, 1'b1, 8'h40, 8'h33, 8'h00, 1'b0);
    tests++;
    if (mem[8'h40] !== 8'h33) begin
      fails++;
      $display("FAIL p1_write_mem: got %h expected 33", mem[8'h40]);
    end
    access(1'b1, 1'b0, 8'h40, 8'h00, 8'h33, 1'b0);
    tests++;
    if (p0_rdata !== 8'd20) begin
      fails++;
      $display("FAIL p0_rdata_hold: got %h expected 14", p0_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h0A, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{port: i[0], rdata: (i[0] ? 8'h33 : 8'd20), err: 1'b0});
      wait_done(10, cyc);
      tests++;
      if (cyc != ((i == 0) ? 2 : 3)) begin
        fails++;
        $display("FAIL rr_spacing_%0d: got %0d cycles expected %0d", i, cyc, (i == 0) ? 2 : 3);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid_op();
    poke(8'h20, 8'h11);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'h20, 8'h55);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (mem_write !== 1'b0) begin
      fails++;
      $display("FAIL rst_gates_write: got mem_write=%b expected 0", mem_write);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tests++;
    if (mem[8'h20] !== 8'h11 || busy !== 1'b0 || p0_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_op: got mem=%h busy=%b d0=%b expected 11 0 0", mem[8'h20], busy, p0_done);
    end
    tests++;
    if (p0_rdata !== 8'h00 || p1_rdata !== 8'h00) begin
      fails++;
      $display("FAIL reset_clears_rdata: got p0=%h p1=%h expected 00 00", p0_rdata, p1_rdata);
    end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (p0_done !== 1'b0 || p1_done !== 1'b0) begin
        fails++;
        $display("FAIL stray_done: got d0=%b d1=%b expected 0 0", p0_done, p1_done);
      end
    end
  endtask

  task automatic test_wrprot();
    poke(8'hF5, 8'h00);
    access(1'b1, 1'b1, 8'hF5, 8'hAA, 8'h00, PROT_ON);
    tests++;
    if (mem[8'hF5] !== (PROT_ON ? 8'h00 : 8'hAA)) begin
      fails++;
      $display("FAIL p1_prot_mem: got %h expected %h", mem[8'hF5], PROT_ON ? 8'h00 : 8'hAA);
    end
    poke(8'hF5, 8'h00);
    access(1'b0, 1'b1, 8'hF5, 8'hAA, 8'h00, 1'b0);
    tests++;
    if (mem[8'hF5] !== 8'hAA) begin
      fails++;
      $display("FAIL p0_prot_mem: got %h expected aa", mem[8'hF5]);
    end
  endtask

  task automatic test_addr_ff();
    access(1'b0, 1'b1, 8'hFF, 8'h5A, 8'h00, 1'b0);
    access(1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0);
    access(1'b0, 1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_back_to_back();
    test_reset_mid_op();
    test_wrprot();
    test_addr_ff();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left: %0d entries remain, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
